// File: rtl/gmm_dma_csr_arbiter.sv
// Shares one descriptor-RAM master and one prefetcher-CSR master between the two
// mSGDMA descriptor generators, with per-client FIFOs and round-robin selection.

module gmm_dma_csr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module gmm_dma_csr_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            c_ram_write,
  input  logic [1:0][5:0]       c_ram_addr,
  input  logic [1:0][255:0]     c_ram_writedata,
  input  logic [1:0]            c_pref_write,
  input  logic [1:0][2:0]       c_pref_addr,
  input  logic [1:0][31:0]      c_pref_writedata,
  output logic                  m_ram_write,
  output logic [6:0]            m_ram_address,
  output logic [255:0]          m_ram_writedata,
  input  logic                  m_ram_waitrequest,
  output logic                  m_pref_write,
  output logic [3:0]            m_pref_address,
  output logic [31:0]           m_pref_writedata,
  input  logic                  m_pref_waitrequest,
  output logic [1:0]            ovf,
  output logic [1:0]            started
);
  localparam int NUM_LANES = 2;
  localparam int RW = 6 + 256;
  localparam int PW = 3 + 32;

  logic [NUM_LANES-1:0]         ram_empty, ram_drop, ram_gnt, ram_busy;
  logic [NUM_LANES-1:0]         pref_empty, pref_drop, pref_gnt, pref_elig;
  logic [NUM_LANES-1:0][RW-1:0] ram_dout;
  logic [NUM_LANES-1:0][PW-1:0] pref_dout;
  logic                         rr_ram, rr_pref, ram_ld, pref_ld;

  function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic rr);
    if (&elig) return rr ? 2'b10 : 2'b01;
    return elig;
  endfunction

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    gmm_dma_csr_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_ram (
      .clk(clk), .rst(rst), .push(c_ram_write[c]), .pop(ram_gnt[c]),
      .din({c_ram_addr[c], c_ram_writedata[c]}), .dout(ram_dout[c]),
      .empty(ram_empty[c]), .drop(ram_drop[c])
    );
    gmm_dma_csr_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_pref (
      .clk(clk), .rst(rst), .push(c_pref_write[c]), .pop(pref_gnt[c]),
      .din({c_pref_addr[c], c_pref_writedata[c]}), .dout(pref_dout[c]),
      .empty(pref_empty[c]), .drop(pref_drop[c])
    );
    // CSR writes wait until this client has nothing queued or in flight on the RAM port.
    assign ram_busy[c]  = m_ram_write && (m_ram_address[6] == 1'(c));
    assign pref_elig[c] = !pref_empty[c] && ram_empty[c] && !ram_busy[c];
  end

  assign ram_ld   = !m_ram_write  || !m_ram_waitrequest;
  assign pref_ld  = !m_pref_write || !m_pref_waitrequest;
  assign ram_gnt  = ram_ld  ? rr_pick(~ram_empty, rr_ram)  : 2'b00;
  assign pref_gnt = pref_ld ? rr_pick(pref_elig, rr_pref)  : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ram_write     <= 1'b0;
      m_ram_address   <= '0;
      m_ram_writedata <= '0;
      rr_ram          <= 1'b0;
    end else if (ram_ld) begin
      m_ram_write <= |ram_gnt;
      if (ram_gnt[1]) begin
        m_ram_address   <= {1'b1, ram_dout[1][RW-1:256]};
        m_ram_writedata <= ram_dout[1][255:0];
      end else if (ram_gnt[0]) begin
        m_ram_address   <= {1'b0, ram_dout[0][RW-1:256]};
        m_ram_writedata <= ram_dout[0][255:0];
      end
      if (&ram_empty == 1'b0 && ram_empty == 2'b00) rr_ram <= ~rr_ram;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pref_write     <= 1'b0;
      m_pref_address   <= '0;
      m_pref_writedata <= '0;
      rr_pref          <= 1'b0;
    end else if (pref_ld) begin
      m_pref_write <= |pref_gnt;
      if (pref_gnt[1]) begin
        m_pref_address   <= {1'b1, pref_dout[1][PW-1:32]};
        m_pref_writedata <= pref_dout[1][31:0];
      end else if (pref_gnt[0]) begin
        m_pref_address   <= {1'b0, pref_dout[0][PW-1:32]};
        m_pref_writedata <= pref_dout[0][31:0];
      end
      if (&pref_elig) rr_pref <= ~rr_pref;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf     <= '0;
      started <= '0;
    end else begin
      ovf <= ovf | ram_drop | pref_drop;
      if (m_pref_write && !m_pref_waitrequest && m_pref_address[2:0] == 3'd0 &&
          m_pref_writedata[0])
        started[m_pref_address[3]] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gmm_dma_csr_arbiter.sv
// Randomized and directed bench against a queue-based transaction model of the arbiter.

module tb_gmm_dma_csr_arbiter;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        c_ram_write;
  logic [1:0][5:0]   c_ram_addr;
  logic [1:0][255:0] c_ram_writedata;
  logic [1:0]        c_pref_write;
  logic [1:0][2:0]   c_pref_addr;
  logic [1:0][31:0]  c_pref_writedata;
  logic              m_ram_write;
  logic [6:0]        m_ram_address;
  logic [255:0]      m_ram_writedata;
  logic              m_ram_waitrequest;
  logic              m_pref_write;
  logic [3:0]        m_pref_address;
  logic [31:0]       m_pref_writedata;
  logic              m_pref_waitrequest;
  logic [1:0]        ovf, started;

  gmm_dma_csr_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .c_ram_write(c_ram_write), .c_ram_addr(c_ram_addr), .c_ram_writedata(c_ram_writedata),
    .c_pref_write(c_pref_write), .c_pref_addr(c_pref_addr), .c_pref_writedata(c_pref_writedata),
    .m_ram_write(m_ram_write), .m_ram_address(m_ram_address),
    .m_ram_writedata(m_ram_writedata), .m_ram_waitrequest(m_ram_waitrequest),
    .m_pref_write(m_pref_write), .m_pref_address(m_pref_address),
    .m_pref_writedata(m_pref_writedata), .m_pref_waitrequest(m_pref_waitrequest),
    .ovf(ovf), .started(started)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-client queues of accepted writes plus the visible master state.
  logic [261:0] q_ram  [2][$];
  logic [34:0]  q_pref [2][$];
  bit           e_ram_wr, e_pref_wr, rr_r, rr_p;
  bit   [6:0]   e_ram_addr;
  bit   [255:0] e_ram_data;
  bit   [3:0]   e_pref_addr;
  bit   [31:0]  e_pref_data;
  bit   [1:0]   e_ovf, e_started;

  function automatic int pick(input bit [1:0] el, input bit rr);
    if (el == 2'b11) return int'(rr);
    if (el[0]) return 0;
    if (el[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      q_ram[c].delete();
      q_pref[c].delete();
    end
    e_ram_wr = 0; e_pref_wr = 0; rr_r = 0; rr_p = 0;
    e_ram_addr = 0; e_ram_data = 0; e_pref_addr = 0; e_pref_data = 0;
    e_ovf = 0; e_started = 0;
  endtask

  task automatic model_step();
    bit ld_r, ld_p;
    bit [1:0] er, ep;
    int w;
    logic [261:0] re;
    logic [34:0] pe;
    ld_r = !e_ram_wr || !m_ram_waitrequest;
    ld_p = !e_pref_wr || !m_pref_waitrequest;
    if (e_pref_wr && !m_pref_waitrequest && e_pref_addr[2:0] == 3'd0 && e_pref_data[0])
      e_started[e_pref_addr[3]] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      er[c] = q_ram[c].size() != 0;
      ep[c] = q_pref[c].size() != 0 && q_ram[c].size() == 0 &&
              !(e_ram_wr && e_ram_addr[6] == 1'(c));
    end
    if (ld_r) begin
      w = pick(er, rr_r);
      if (er == 2'b11) rr_r = !rr_r;
      e_ram_wr = (w >= 0);
      if (w >= 0) begin
        re = q_ram[w].pop_front();
        e_ram_addr = {1'(w), re[261:256]};
        e_ram_data = re[255:0];
      end
    end
    if (ld_p) begin
      w = pick(ep, rr_p);
      if (ep == 2'b11) rr_p = !rr_p;
      e_pref_wr = (w >= 0);
      if (w >= 0) begin
        pe = q_pref[w].pop_front();
        e_pref_addr = {1'(w), pe[34:32]};
        e_pref_data = pe[31:0];
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (c_ram_write[c]) begin
        if (q_ram[c].size() < DEPTH) q_ram[c].push_back({c_ram_addr[c], c_ram_writedata[c]});
        else e_ovf[c] = 1'b1;
      end
      if (c_pref_write[c]) begin
        if (q_pref[c].size() < DEPTH) q_pref[c].push_back({c_pref_addr[c], c_pref_writedata[c]});
        else e_ovf[c] = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("ram_write", 256'(m_ram_write), 256'(e_ram_wr));
    if (e_ram_wr) begin
      chk("ram_addr", 256'(m_ram_address), 256'(e_ram_addr));
      chk("ram_data", m_ram_writedata, e_ram_data);
    end
    chk("pref_write", 256'(m_pref_write), 256'(e_pref_wr));
    if (e_pref_wr) begin
      chk("pref_addr", 256'(m_pref_address), 256'(e_pref_addr));
      chk("pref_data", 256'(m_pref_writedata), 256'(e_pref_data));
    end
    chk("ovf", 256'(ovf), 256'(e_ovf));
    chk("started", 256'(started), 256'(e_started));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    @(negedge clk);
    compare();
    c_ram_write  = 2'b00;
    c_pref_write = 2'b00;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_rand(input int pr, input int pp, input int pw);
    for (int c = 0; c < 2; c++) begin
      c_ram_write[c]      = $urandom_range(99) < pr;
      c_ram_addr[c]       = 6'($urandom);
      c_ram_writedata[c]  = rnd256();
      c_pref_write[c]     = $urandom_range(99) < pp;
      c_pref_addr[c]      = ($urandom_range(3) == 0) ? 3'd0 : 3'($urandom);
      c_pref_writedata[c] = $urandom;
    end
    m_ram_waitrequest  = $urandom_range(99) < pw;
    m_pref_waitrequest = $urandom_range(99) < pw;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    c_ram_write = 0; c_ram_addr = 0; c_ram_writedata = 0;
    c_pref_write = 0; c_pref_addr = 0; c_pref_writedata = 0;
    m_ram_waitrequest = 0; m_pref_waitrequest = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ram_write", 256'(m_ram_write), 256'(0));
    chk("rst_ram_addr", 256'(m_ram_address), 256'(0));
    chk("rst_ram_data", m_ram_writedata, 256'(0));
    chk("rst_pref_write", 256'(m_pref_write), 256'(0));
    chk("rst_pref_addr", 256'(m_pref_address), 256'(0));
    chk("rst_pref_data", 256'(m_pref_writedata), 256'(0));
    chk("rst_ovf", 256'(ovf), 256'(0));
    chk("rst_started", 256'(started), 256'(0));
    rst = 1'b1;

    // Client 0 streams four RAM writes; first output two clocks after first strobe.
    for (int i = 0; i < 4; i++) begin
      c_ram_write = 2'b01; c_ram_addr[0] = 6'(i); c_ram_writedata[0] = rnd256();
      tick();
      if (i == 1) chk("lat_first_addr", 256'(m_ram_address), 256'(7'h00));
    end
    repeat (6) tick();

    // Both clients hammer addr 5: alternating 0x05 / 0x45, client 0 first.
    for (int i = 0; i < 4; i++) begin
      c_ram_write = 2'b11; c_ram_addr[0] = 6'd5; c_ram_addr[1] = 6'd5;
      c_ram_writedata[0] = rnd256(); c_ram_writedata[1] = rnd256();
      tick();
    end
    repeat (10) tick();

    // Client 1 RAM then CSR writes behind a stalled RAM port.
    m_ram_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_ram_write = 2'b10; c_ram_addr[1] = 6'(i + 8); c_ram_writedata[1] = rnd256();
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      c_pref_write = 2'b10; c_pref_addr[1] = 3'(2 - i);
      c_pref_writedata[1] = (i == 2) ? 32'h11 : 32'($urandom);
      tick();
    end
    repeat (3) tick();
    m_ram_waitrequest = 1'b0;
    repeat (15) tick();
    chk("started_c1", 256'(started), 256'(2'b10));

    // CSR stall mid-write: held values checked every cycle by the model.
    c_pref_write = 2'b01; c_pref_addr[0] = 3'd3; c_pref_writedata[0] = 32'hcafe_f00d;
    tick();
    m_pref_waitrequest = 1'b1;
    repeat (5) tick();
    m_pref_waitrequest = 1'b0;
    repeat (4) tick();

    // Overflow: six RAM strobes against a stuck port.
    do_reset();
    m_ram_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_ram_write = 2'b01; c_ram_addr[0] = 6'(i + 16); c_ram_writedata[0] = rnd256();
      tick();
    end
    repeat (2) tick();
    chk("ovf_c0", 256'(ovf), 256'(2'b01));
    m_ram_waitrequest = 1'b0;
    repeat (10) tick();

    // Randomized traffic, alternating light and congested phases.
    for (int ph = 0; ph < 6; ph++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        drive_rand((ph % 2) ? 60 : 25, (ph % 2) ? 40 : 15, (ph % 2) ? 60 : 20);
        tick();
      end
      m_ram_waitrequest = 0; m_pref_waitrequest = 0;
      repeat (20) tick();
    end

    // Asynchronous reset during a stalled CSR write.
    do_reset();
    m_pref_waitrequest = 1'b1;
    c_pref_write = 2'b01; c_pref_addr[0] = 3'd0; c_pref_writedata[0] = 32'h1;
    tick();
    for (int i = 0; i < 10 && !e_pref_wr; i++) tick();
    chk("pref_stalled", 256'(m_pref_write), 256'(1));
    #2 rst = 1'b0;
    #1 chk("pref_async_rst", 256'(m_pref_write), 256'(0));
    model_reset();
    tick();
    m_pref_waitrequest = 1'b0;
    rst = 1'b1;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gmm_dma_csr_arbiter.md
# gmm_dma_csr_arbiter

Shares one descriptor-RAM Avalon-MM master and one prefetcher-CSR Avalon-MM master between the two mSGDMA descriptor generators (client 0 = read-side, client 1 = write-side). Each generator emits single-cycle writes with no backpressure; this block buffers them per client and arbitrates them round-robin onto the shared masters. It enforces the ordering rule that a client's CSR writes are issued only after all of its descriptor writes have been accepted. It sits between the generators and the interconnect to the prefetchers.

## Interface
- FIFO_DEPTH, 4: entries per client per port; power of 2, ≥2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- c_ram_write  in  2  per-client descriptor write strobe; bit c = client c.
- c_ram_addr  in  2×6  per-client descriptor word index.
- c_ram_writedata  in  2×256  per-client descriptor.
- c_pref_write  in  2  per-client CSR write strobe.
- c_pref_addr  in  2×3  per-client CSR index.
- c_pref_writedata  in  2×32  per-client CSR data.
- m_ram_write  out  1  descriptor RAM write.
- m_ram_address  out  7  {client, addr[5:0]}.
- m_ram_writedata  out  256  descriptor data.
- m_ram_waitrequest  in  1  Avalon stall.
- m_pref_write  out  1  CSR write.
- m_pref_address  out  4  {client, addr[2:0]}.
- m_pref_writedata  out  32  CSR data.
- m_pref_waitrequest  in  1  Avalon stall.
- ovf  out  2  sticky per-client overflow, set on any dropped write.
- started  out  2  sticky, set when client's CSR write to addr 0 with data bit 0 = 1 is accepted.

## Operation
- Four FIFOs: RAM[c], PREF[c], c ∈ {0,1}; each entry stores {addr, data}.
- Push: a strobe at a rising edge pushes into the matching FIFO. If it is full, the write is dropped and ovf[c] is set; FIFO contents are unchanged. Push to a full FIFO while it pops in the same cycle is accepted (no drop).
- Each master port has its own output register and its own round-robin pointer (rr_ram, rr_pref; reset 0 = client 0 preferred).
- Load: when the output register is empty, or holds a write accepted this cycle (write=1, waitrequest=0), the port pops one eligible FIFO and loads it.
  - If both clients are eligible, the preferred one wins and the pointer then prefers the other.
  - If only one is eligible, it wins and the pointer is unchanged.
- RAM[c] is eligible when non-empty.
- PREF[c] is eligible when non-empty, RAM[c] is empty, and the RAM output register does not hold a client-c write. A client-c RAM write loaded or held this cycle blocks PREF[c].
- Hold: while write=1 and waitrequest=1, address, data and write stay stable; no pop occurs for that port.
- started[c] is set on the accepting cycle of the qualifying PREF write.
- Reset mid-operation: all FIFOs are flushed, outputs are cleared, pointers return to 0, and ovf and started are cleared. No partial writes are held.

## Timing
- Reset values: every output is 0 (write strobes, addresses, data, ovf, started). All FIFO levels are 0.
- Latency: a strobe at edge N is pushed at N. If the port is idle and no other entry is queued, m_*_write is high in the cycle after edge N+1, i.e. 2 clocks strobe-to-output.
- Throughput: 1 write/cycle per port with waitrequest low, so back-to-back writes from one client stream without bubbles.
- Ordering: per client, per port, FIFO order is preserved. Across ports, the only guarantee is RAM-before-PREF for the same client.
- The two ports operate fully independently except for the PREF eligibility rule.

## Test plan
- Single client 0 sends 4 RAM writes on consecutive cycles with waitrequest=0 → m_ram_address 0x00..0x03 on 4 consecutive cycles starting 2 clocks after the first strobe. ovf=0.
- Both clients strobe RAM addr 5 every cycle for 4 cycles → outputs alternate 0x05, 0x45, 0x05, 0x45…, client 0 first. No drops at FIFO_DEPTH=4.
- Client 1 sends 4 RAM writes, then immediately PREF addr 2, 1, 0 (data 0x11 on addr 0); m_ram_waitrequest is held high 10 cycles → no m_pref_write until the 4th RAM write is accepted. Then PREF addresses 0xA, 0x9, 0x8 are issued and started=2'b10.
- m_pref_waitrequest high for 5 cycles mid-write → m_pref_address/data remain stable throughout. The write completes once, with no duplicate.
- Client 0 strobes 6 RAM writes while m_ram_waitrequest is stuck high → 1 held in the output register plus 4 in the FIFO, the 6th is dropped and ovf=2'b01. After release, exactly 5 writes appear.
- Reset asserted during a stalled PREF write → m_pref_write=0 immediately (asynchronous). After deassertion, no residual writes appear and started=0, ovf=0.
